// File: rtl/serializer_feed_fifo.sv
// serializer_feed_fifo: buffers wide words and hands them one at a time, as
// single-cycle valid pulses, to a downstream serializer whenever it is idle.
`default_nettype none

module serializer_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WIDTH*N-1:0]       in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [WIDTH*N-1:0]       ser_data_o,
  output logic                     ser_valid_o,
  input  logic                     ser_busy_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = WIDTH * N;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] ser_data_q, ser_data_d;
  logic          ser_valid_q, ser_valid_d;
  logic          overflow_q, overflow_d;
  logic          full, push, issue;

  always_comb begin
    full  = (level_q == LW'(DEPTH));
    push  = in_valid_i && !full;
    // The !ser_valid_q term keeps every pulse one cycle long; the serializer
    // raises busy on the edge that ends it.
    issue = (level_q != '0) && !ser_busy_i && !ser_valid_q;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = issue;
    overflow_d  = overflow_q | (in_valid_i & full);
    level_d     = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      ser_data_d = mem_q[rd_ptr_q];
    end

    case ({push, issue})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ser_data_q  <= '0;
      ser_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready_o  = !full;
  assign ser_data_o  = ser_data_q;
  assign ser_valid_o = ser_valid_q;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;

endmodule

`default_nettype wire
